display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 114 +++++++++++
 tb/tb_display_scan_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with a double-buffered display value.
// Each digit is lit for div+1 cycles, then all digits are dark for BLANK_CYC cycles.
module display_scan_ctrl #(
   parameter int DIV_W     = 16,
   parameter int BLANK_CYC = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [DIV_W-1:0] div,
   input  logic             load_valid,
   input  logic [15:0]      load_data,
   output logic             load_ready,
   input  logic             lz_blank_en,
   output logic [1:0]       SEL,
   output logic [3:0]       CAT,
   output logic [3:0]       NIBBLE,
   output logic             frame_done
);

   // state   | meaning
   // SCAN    | digit SEL is lit; the prescaler counts up to div
   // GAP     | all digits dark; the gap counter counts down BLANK_CYC cycles
   typedef enum logic {ST_SCAN, ST_GAP} state_t;

   localparam logic [3:0] GAP_LOAD = 4'(BLANK_CYC - 1);

   state_t           state;
   logic [DIV_W-1:0] presc;
   logic [3:0]       gap_cnt;
   logic [1:0]       sel;
   logic [15:0]      shadow;
   logic [15:0]      pending;
   logic             full;
   logic             lead0, lead1, lead2;

   always_ff @(negedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_SCAN;
         presc      <= '0;
         gap_cnt    <= '0;
         sel        <= 2'd0;
         shadow     <= 16'h0000;
         pending    <= 16'h0000;
         full       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         // Accept only into an empty pending slot; the boundary copy only
         // fires when the slot is full, so the two never collide.
         if (load_valid && !full) begin
            pending <= load_data;
            full    <= 1'b1;
         end
         case (state)
            ST_SCAN: begin
               if (presc >= div) begin
                  presc   <= '0;
                  gap_cnt <= GAP_LOAD;
                  state   <= ST_GAP;
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_cnt == 4'd0) begin
                  state <= ST_SCAN;
                  sel   <= sel + 1'b1;
                  if (sel == 2'd3) begin
                     frame_done <= 1'b1;
                     if (full) begin
                        shadow <= pending;
                        full   <= 1'b0;
                     end
                  end
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: state <= ST_SCAN;
         endcase
      end
   end

   assign load_ready = ~full;
   assign SEL        = sel;

   // A digit is blanked when it and every digit to its left hold zero.
   assign lead0 = (shadow[15:12] == 4'h0);
   assign lead1 = lead0 && (shadow[11:8] == 4'h0);
   assign lead2 = lead1 && (shadow[7:4] == 4'h0);

   always_comb begin
      NIBBLE = 4'h0;
      case (sel)
         2'd0:    NIBBLE = shadow[15:12];
         2'd1:    NIBBLE = shadow[11:8];
         2'd2:    NIBBLE = shadow[7:4];
         default: NIBBLE = shadow[3:0];
      endcase
   end

   always_comb begin
      CAT = 4'b0000;
      if (state == ST_SCAN) begin
         case (sel)
            2'd0:    CAT = (lz_blank_en && lead0) ? 4'b0000 : 4'b1000;
            2'd1:    CAT = (lz_blank_en && lead1) ? 4'b0000 : 4'b0100;
            2'd2:    CAT = (lz_blank_en && lead2) ? 4'b0000 : 4'b0010;
            default: CAT = 4'b0001;
         endcase
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: accepted loads are queued, and each
// captured frame is compared against a frame built from the display rules.
module tb_display_scan_ctrl;
   localparam int DIV_W     = 16;
   localparam int BLANK_CYC = 4;
   localparam int CAP_MAX   = 512;

   logic             clock = 1'b1;
   logic             reset = 1'b0;
   logic [DIV_W-1:0] div = '0;
   logic             load_valid = 1'b0;
   logic [15:0]      load_data = 16'h0;
   logic             load_ready;
   logic             lz_blank_en = 1'b0;
   logic [1:0]       SEL;
   logic [3:0]       CAT;
   logic [3:0]       NIBBLE;
   logic             frame_done;

   display_scan_ctrl #(.DIV_W(DIV_W), .BLANK_CYC(BLANK_CYC)) dut (
      .clock(clock), .reset(reset), .div(div),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .lz_blank_en(lz_blank_en), .SEL(SEL), .CAT(CAT), .NIBBLE(NIBBLE),
      .frame_done(frame_done)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] val;
      time         t;
   } load_t;
   load_t sb_q[$];

   logic        mon_en = 1'b0;
   time         last_bnd_t = 0;
   logic [15:0] cur_val = 16'h0;
   logic [3:0]  cap_cat [CAP_MAX];
   logic [3:0]  cap_nib [CAP_MAX];
   logic [1:0]  cap_sel [CAP_MAX];
   logic        cap_fd  [CAP_MAX];
   int          cap_n = 0;
   logic        cap_active = 1'b0;
   logic [15:0] cap_val = 16'h0;
   int          cap_div = 0;
   logic        cap_lz = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] nib_of(input logic [15:0] v, input int d);
      logic [15:0] t;
      t = v >> (4 * (3 - d));
      return t[3:0];
   endfunction

   function automatic logic blanked(input logic [15:0] v, input int d, input logic lz);
      if (!lz || d == 3) return 1'b0;
      for (int k = 0; k <= d; k++)
         if (nib_of(v, k) != 4'h0) return 1'b0;
      return 1'b1;
   endfunction

   // Expected frame: digit d lit for div+1 cycles then dark BLANK_CYC cycles.
   task automatic check_frame();
      int slot, len, bad, d, r;
      logic [3:0] ecat, enib;
      slot = cap_div + 1 + BLANK_CYC;
      len  = 4 * slot;
      bad  = -1;
      ecat = 4'h0;
      enib = 4'h0;
      chk("frame_len", cap_n, len);
      if (cap_n == len) begin
         for (int i = 0; i < len; i++) begin
            d = i / slot;
            r = i % slot;
            ecat = (r <= cap_div && !blanked(cap_val, d, cap_lz)) ? (4'b1000 >> d) : 4'b0000;
            enib = nib_of(cap_val, d);
            if (bad < 0 && (cap_cat[i] !== ecat || cap_nib[i] !== enib ||
                            cap_sel[i] !== 2'(d) || cap_fd[i] !== (i == 0))) begin
               bad = i;
               checks++;
               failures++;
               $display("FAIL frame_trace: val=%h idx=%0d got cat=%b nib=%h sel=%0d fd=%b expected cat=%b nib=%h sel=%0d fd=%b",
                        cap_val, i, cap_cat[i], cap_nib[i], cap_sel[i], cap_fd[i],
                        ecat, enib, d, (i == 0));
            end
         end
         if (bad < 0) checks++;
      end
   endtask

   always @(negedge clock) begin
      if (reset && load_valid && load_ready)
         sb_q.push_back('{val: load_data, t: $time});
   end

   always @(posedge clock) begin
      if (!reset) begin
         sb_q.delete();
         cur_val    = 16'h0;
         cap_active = 1'b0;
      end else begin
         if (frame_done) begin
            last_bnd_t = $time - 5;
            if (sb_q.size() > 0 && sb_q[0].t < last_bnd_t)
               cur_val = sb_q.pop_front().val;
            if (cap_active && mon_en) check_frame();
            cap_active = mon_en;
            cap_n      = 0;
            cap_val    = cur_val;
            cap_div    = int'(div);
            cap_lz     = lz_blank_en;
         end
         if (!mon_en) cap_active = 1'b0;
         if (cap_active) begin
            if (cap_n < CAP_MAX) begin
               cap_cat[cap_n] = CAT;
               cap_nib[cap_n] = NIBBLE;
               cap_sel[cap_n] = SEL;
               cap_fd[cap_n]  = frame_done;
            end
            cap_n++;
         end
      end
   end

   task automatic do_load(input logic [15:0] v, output time acc_t);
      logic ok;
      ok        = 1'b0;
      acc_t     = 0;
      load_data = v;
      load_valid = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clock);
         if (load_ready && reset) begin
            ok    = 1'b1;
            acc_t = $time;
            break;
         end
      end
      @(posedge clock);
      load_valid = 1'b0;
      chk("load_accept", ok, 1);
   endtask

   task automatic wait_frames(input int n);
      logic seen;
      for (int f = 0; f < n; f++) begin
         seen = 1'b0;
         for (int c = 0; c < 2000; c++) begin
            @(posedge clock);
            if (frame_done) begin
               seen = 1'b1;
               break;
            end
         end
         chk("frame_wait", seen, 1);
      end
   endtask

   task automatic set_mode(input logic [DIV_W-1:0] d, input logic lz);
      mon_en = 1'b0;
      @(posedge clock);
      div         = d;
      lz_blank_en = lz;
      @(posedge clock);
      mon_en = 1'b1;
   endtask

   initial begin
      time         t_acc;
      logic [15:0] v;
      logic        seen;

      // reset values, with and without leading-zero blanking
      #1;
      chk("rst_sel", SEL, 0);
      chk("rst_cat_lz0", CAT, 4'b1000);
      chk("rst_nibble", NIBBLE, 0);
      chk("rst_ready", load_ready, 1);
      chk("rst_frame_done", frame_done, 0);
      lz_blank_en = 1'b1;
      #1;
      chk("rst_cat_lz1", CAT, 4'b0000);
      lz_blank_en = 1'b0;
      div = 16'd3;
      #10;
      chk("rst_hold_sel", SEL, 0);
      chk("rst_hold_cat", CAT, 4'b1000);
      @(posedge clock);
      #2 reset = 1'b1;
      mon_en = 1'b1;

      // basic frame timing with 0x1234
      do_load(16'h1234, t_acc);
      wait_frames(3);

      // back-to-back loads: second one stalls until the boundary frees pending
      do_load(16'hAAAA, t_acc);
      #1 chk("ready_after_accept", load_ready, 0);
      do_load(16'h5555, t_acc);
      chk("accept_after_boundary", 32'(t_acc - last_bnd_t), 32'd10);
      wait_frames(3);

      // leading-zero blanking
      set_mode(16'd3, 1'b1);
      do_load(16'h0005, t_acc);
      wait_frames(2);
      do_load(16'h0000, t_acc);
      wait_frames(2);
      do_load(16'h0100, t_acc);
      wait_frames(2);

      // one-cycle digits
      set_mode(16'd0, 1'b0);
      do_load(16'h9C07, t_acc);
      wait_frames(3);

      // lowering div below the running count ends SCAN at the next edge
      mon_en = 1'b0;
      div = 16'd100;
      wait_frames(2);
      repeat (50) @(negedge clock);
      @(posedge clock);
      chk("div_chg_pre", CAT, 4'b1000);
      div = 16'd2;
      @(posedge clock);
      chk("div_chg_gap", CAT, 4'b0000);

      // randomized segments
      for (int seg = 0; seg < 6; seg++) begin
         set_mode((seg == 0) ? 16'd0 : 16'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
         for (int j = 0; j < 4; j++) begin
            v = 16'($urandom);
            for (int k = 0; k < 4; k++)
               if ($urandom_range(0, 2) == 0) v[4*k +: 4] = 4'h0;
            do_load(v, t_acc);
            repeat ($urandom_range(0, 40)) @(posedge clock);
         end
         wait_frames(2);
      end
      chk("sb_drained", sb_q.size(), 0);

      // reset in GAP with pending full: pending value must never appear
      set_mode(16'd3, 1'b0);
      do_load(16'h1234, t_acc);
      wait_frames(2);
      do_load(16'hBEEF, t_acc);
      seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clock);
         if (CAT == 4'b0000) begin
            seen = 1'b1;
            break;
         end
      end
      chk("gap_reached", seen, 1);
      chk("pending_full_pre_reset", load_ready, 0);
      #2 reset = 1'b0;
      #1;
      chk("arst_sel", SEL, 0);
      chk("arst_cat", CAT, 4'b1000);
      chk("arst_nibble", NIBBLE, 0);
      chk("arst_ready", load_ready, 1);
      chk("arst_frame_done", frame_done, 0);
      repeat (2) @(posedge clock);
      #2 reset = 1'b1;
      wait_frames(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
